// File: rtl/mix_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// mix_fifo_wr_arb
//
// Round-robin burst arbiter sharing the single write port of one prefetch
// mix FIFO between N_SRC video stream sources. One source owns the port at a
// time for up to BURST_LEN data beats (fewer if it signals last). When
// HDR_EN=1 a header word {4'hF, 0..., grant_id} precedes each burst so the
// read side can demultiplex.
//
// Ports:
//   i_clk          single clock
//   i_rst          synchronous active-high reset
//   i_src_req      per-source burst pending (level)
//   i_src_vld      per-source beat valid
//   i_src_data     per-source data, source i in [i*DATA_W +: DATA_W]
//   i_src_last     per-source final beat of packet
//   o_src_rdy      per-source beat accept (beat taken when vld & rdy)
//   o_fifo_wr_en   FIFO write enable
//   o_fifo_wr_data FIFO write data
//   i_fifo_wr_rdy  FIFO accepts a write this cycle
//   o_grant        one-hot current owner, 0 when idle
//   o_grant_id     binary owner index, 0 when idle
//   o_busy         arbiter is not idle
// ---------------------------------------------------------------------------
module mix_fifo_wr_arb #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_LEN = 64,
    parameter int unsigned HDR_EN    = 1,
    parameter int unsigned ID_W      = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_SRC-1:0]          i_src_req,
    input  logic [N_SRC-1:0]          i_src_vld,
    input  logic [N_SRC*DATA_W-1:0]   i_src_data,
    input  logic [N_SRC-1:0]          i_src_last,
    output logic [N_SRC-1:0]          o_src_rdy,
    output logic                      o_fifo_wr_en,
    output logic [DATA_W-1:0]         o_fifo_wr_data,
    input  logic                      i_fifo_wr_rdy,
    output logic [N_SRC-1:0]          o_grant,
    output logic [ID_W-1:0]           o_grant_id,
    output logic                      o_busy
);

    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_XFER
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [N_SRC-1:0]    r_grant;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     r_last;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_arb_found;
    logic [ID_W-1:0]     w_arb_id;

    logic                w_own_vld;
    logic                w_own_last;
    logic [DATA_W-1:0]   w_own_data;

    logic [DATA_W-1:0]   w_hdr;
    logic                w_acc;
    logic                w_burst_end;

    // Round-robin pick: first requester scanning from r_last+1 with wrap.
    // Constant-indexed double loop keeps every select a fixed bit position.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_id    = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            for (int unsigned j = 0; j < N_SRC; j++) begin
                if (!w_arb_found && i_src_req[j] &&
                    (j == ((32'(r_last) + k) % N_SRC))) begin
                    w_arb_found = 1'b1;
                    w_arb_id    = ID_W'(j);
                end
            end
        end
    end

    // Owner signal mux driven by the one-hot grant.
    always_comb begin
        w_own_vld  = 1'b0;
        w_own_last = 1'b0;
        w_own_data = '0;
        for (int unsigned j = 0; j < N_SRC; j++) begin
            if (r_grant[j]) begin
                w_own_vld  = i_src_vld[j];
                w_own_last = i_src_last[j];
                w_own_data = i_src_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Header word: top nibble 4'hF, source ID in the low bits.
    always_comb begin
        w_hdr                  = '0;
        w_hdr[DATA_W-1 -: 4]   = 4'hF;
        w_hdr[ID_W-1:0]        = r_grant_id;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        o_fifo_wr_en   = 1'b0;
        o_fifo_wr_data = '0;
        o_src_rdy      = '0;
        w_acc          = 1'b0;
        w_burst_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_found) begin
                    w_next = (HDR_EN != 0) ? ST_HDR : ST_XFER;
                end
            end
            ST_HDR: begin
                o_fifo_wr_en   = 1'b1;
                o_fifo_wr_data = w_hdr;
                if (i_fifo_wr_rdy) begin
                    w_next = ST_XFER;
                end
            end
            ST_XFER: begin
                o_fifo_wr_en   = w_own_vld;
                o_fifo_wr_data = w_own_data;
                o_src_rdy      = r_grant & {N_SRC{i_fifo_wr_rdy}};
                w_acc          = w_own_vld & i_fifo_wr_rdy;
                w_burst_end    = w_acc & (w_own_last | (r_cnt == CNT_MAX));
                if (w_burst_end) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_last     <= ID_W'(N_SRC - 1);
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_found) begin
                        r_grant    <= N_SRC'(1) << w_arb_id;
                        r_grant_id <= w_arb_id;
                        r_last     <= w_arb_id;
                    end
                end
                ST_XFER: begin
                    if (w_burst_end) begin
                        r_cnt      <= '0;
                        r_grant    <= '0;
                        r_grant_id <= '0;
                    end else if (w_acc) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_grant    = r_grant;
    assign o_grant_id = r_grant_id;
    assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mix_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_mix_fifo_wr_arb
//
// Directed self-checking bench for mix_fifo_wr_arb (N_SRC=4, DATA_W=16,
// BURST_LEN=4, HDR_EN=1, ID_W=3). Inputs change 1 time unit after a rising
// edge; outputs are checked 1 unit later. Accepted FIFO writes are logged on
// the falling edge and compared against hand-computed word lists.
// ---------------------------------------------------------------------------
module tb_mix_fifo_wr_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  src_req;
    logic [3:0]  src_vld;
    logic [63:0] src_data;
    logic [3:0]  src_last;
    logic [3:0]  src_rdy;
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic        fifo_wr_rdy;
    logic [3:0]  grant;
    logic [2:0]  grant_id;
    logic        busy;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [15:0] wq[$];

    mix_fifo_wr_arb #(
        .N_SRC     (4),
        .DATA_W    (16),
        .BURST_LEN (4),
        .HDR_EN    (1),
        .ID_W      (3)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_src_req      (src_req),
        .i_src_vld      (src_vld),
        .i_src_data     (src_data),
        .i_src_last     (src_last),
        .o_src_rdy      (src_rdy),
        .o_fifo_wr_en   (fifo_wr_en),
        .o_fifo_wr_data (fifo_wr_data),
        .i_fifo_wr_rdy  (fifo_wr_rdy),
        .o_grant        (grant),
        .o_grant_id     (grant_id),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A write lands in the FIFO at the next rising edge; inputs are stable
    // from edge+1 onward, so the falling edge sees the committing values.
    always @(negedge clk) begin
        if (!rst && fifo_wr_en && fifo_wr_rdy) begin
            wq.push_back(fifo_wr_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [15:0] exp);
        logic [15:0] v;
        v = 'x;
        if (wq.size() > 0) v = wq.pop_front();
        chk(tag, {16'h0, v}, {16'h0, exp});
    endtask

    task automatic set_data(input int unsigned idx, input logic [15:0] v);
        src_data[idx*16 +: 16] = v;
    endtask

    initial begin
        logic        acc;
        int unsigned n;
        int unsigned cyc;
        int unsigned idle;
        bit          done;

        rst         = 1'b1;
        src_req     = 4'b1111;
        src_vld     = 4'b0000;
        src_last    = 4'b0000;
        src_data    = '0;
        fifo_wr_rdy = 1'b1;

        // ---- reset with all requests asserted ----
        tick();
        tick();
        settle();
        chk("rst_grant",   {28'h0, grant}, 32'h0);
        chk("rst_gid",     {29'h0, grant_id}, 32'h0);
        chk("rst_busy",    {31'h0, busy}, 32'h0);
        chk("rst_src_rdy", {28'h0, src_rdy}, 32'h0);
        chk("rst_wr_en",   {31'h0, fifo_wr_en}, 32'h0);
        chk("rst_wr_data", {16'h0, fifo_wr_data}, 32'h0);
        rst = 1'b0;

        // ---- source 0: 3-beat packet ----
        tick();
        src_req = 4'b0001;
        src_vld = 4'b0001;
        set_data(0, 16'h0011);
        settle();
        chk("t1_grant",   {28'h0, grant}, 32'h1);
        chk("t1_hdr_en",  {31'h0, fifo_wr_en}, 32'h1);
        chk("t1_hdr",     {16'h0, fifo_wr_data}, 32'hF000);
        chk("t1_hdr_rdy", {28'h0, src_rdy}, 32'h0);
        tick();
        chk("t1_d0",      {16'h0, fifo_wr_data}, 32'h0011);
        chk("t1_d0_rdy",  {28'h0, src_rdy}, 32'h1);
        tick();
        set_data(0, 16'h0022);
        tick();
        set_data(0, 16'h0033);
        src_last = 4'b0001;
        settle();
        chk("t1_busy_last", {31'h0, busy}, 32'h1);
        tick();
        src_req  = 4'b0000;
        src_vld  = 4'b0000;
        src_last = 4'b0000;
        settle();
        chk("t1_busy_end",  {31'h0, busy}, 32'h0);
        chk("t1_grant_end", {28'h0, grant}, 32'h0);
        chk_wr("t1_w0", 16'hF000);
        chk_wr("t1_w1", 16'h0011);
        chk_wr("t1_w2", 16'h0022);
        chk_wr("t1_w3", 16'h0033);
        chk("t1_wq_empty", wq.size(), 32'd0);

        // ---- source 2: 10 beats split into 4+4+2 bursts ----
        src_req = 4'b0100;
        src_vld = 4'b0100;
        n = 1;
        set_data(2, 16'h0201);
        cyc  = 0;
        idle = 0;
        done = 1'b0;
        settle();
        for (int c = 0; c < 40 && !done; c++) begin
            acc = src_rdy[2];
            tick();
            cyc++;
            if (acc) n++;
            if (n > 10) begin
                done    = 1'b1;
                src_req = 4'b0000;
                src_vld = 4'b0000;
                src_last = 4'b0000;
            end else begin
                set_data(2, 16'h0200 + 16'(n));
                src_last = (n == 10) ? 4'b0100 : 4'b0000;
                settle();
                if (!busy) idle++;
            end
        end
        chk("t3_done",  {31'h0, done}, 32'h1);
        chk("t3_cycles", cyc, 32'd16);
        chk("t3_idle",   idle, 32'd2);
        n = 1;
        for (int b = 0; b < 3; b++) begin
            chk_wr("t3_hdr", 16'hF002);
            for (int k = 0; k < ((b == 2) ? 2 : 4); k++) begin
                chk_wr("t3_dat", 16'h0200 + 16'(n));
                n++;
            end
        end
        chk("t3_wq_empty", wq.size(), 32'd0);

        // ---- reset, then all four request 1-beat packets ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src_req  = 4'b1111;
        src_vld  = 4'b1111;
        src_last = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 16'h0A00 + 16'(i));
        for (int b = 0; b < 5; b++) begin
            tick();
            chk("t4_grant", {28'h0, grant}, 32'(4'b0001 << (b % 4)));
            chk("t4_hdr",   {16'h0, fifo_wr_data}, 32'hF000 + 32'(b % 4));
            tick();
            chk("t4_dat",   {16'h0, fifo_wr_data}, 32'h0A00 + 32'(b % 4));
            chk("t4_rdy",   {28'h0, src_rdy}, 32'(4'b0001 << (b % 4)));
            tick();
            chk("t4_busy",  {31'h0, busy}, 32'h0);
        end
        src_req  = 4'b0000;
        src_vld  = 4'b0000;
        src_last = 4'b0000;
        for (int b = 0; b < 5; b++) begin
            chk_wr("t4_whdr", 16'hF000 + 16'(b % 4));
            chk_wr("t4_wdat", 16'h0A00 + 16'(b % 4));
        end
        chk("t4_wq_empty", wq.size(), 32'd0);

        // ---- backpressure on source 1, 4 beats capped by BURST_LEN ----
        src_req = 4'b0010;
        src_vld = 4'b0010;
        set_data(1, 16'h1100);
        fifo_wr_rdy = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t5_hdr_en",  {31'h0, fifo_wr_en}, 32'h1);
            chk("t5_hdr_hold", {16'h0, fifo_wr_data}, 32'hF001);
            chk("t5_hdr_rdy", {28'h0, src_rdy}, 32'h0);
            tick();
        end
        fifo_wr_rdy = 1'b1;
        tick();
        chk("t5_d0",     {16'h0, fifo_wr_data}, 32'h1100);
        chk("t5_d0_rdy", {28'h0, src_rdy}, 32'h2);
        tick();
        set_data(1, 16'h1101);
        fifo_wr_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t5_dat_hold", {16'h0, fifo_wr_data}, 32'h1101);
            chk("t5_dat_rdy",  {28'h0, src_rdy}, 32'h0);
            tick();
        end
        fifo_wr_rdy = 1'b1;
        tick();
        set_data(1, 16'h1102);
        tick();
        set_data(1, 16'h1103);
        settle();
        chk("t5_busy_b4", {31'h0, busy}, 32'h1);
        tick();
        src_req = 4'b0000;
        src_vld = 4'b0000;
        settle();
        chk("t5_busy_end",  {31'h0, busy}, 32'h0);
        chk("t5_grant_end", {28'h0, grant}, 32'h0);
        chk_wr("t5_w0", 16'hF001);
        chk_wr("t5_w1", 16'h1100);
        chk_wr("t5_w2", 16'h1101);
        chk_wr("t5_w3", 16'h1102);
        chk_wr("t5_w4", 16'h1103);
        chk("t5_wq_empty", wq.size(), 32'd0);

        // ---- reset on beat 2 of a source 1 burst ----
        src_req = 4'b0010;
        src_vld = 4'b0010;
        set_data(1, 16'h5500);
        tick();
        tick();
        chk("t6_d0", {16'h0, fifo_wr_data}, 32'h5500);
        tick();
        set_data(1, 16'h5501);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        src_req  = 4'b0110;
        src_vld  = 4'b0110;
        src_last = 4'b0110;
        set_data(1, 16'h5510);
        set_data(2, 16'h6600);
        settle();
        chk("t6_rst_en",    {31'h0, fifo_wr_en}, 32'h0);
        chk("t6_rst_grant", {28'h0, grant}, 32'h0);
        chk("t6_rst_busy",  {31'h0, busy}, 32'h0);
        tick();
        chk("t6_regrant",   {28'h0, grant}, 32'h2);
        chk("t6_hdr",       {16'h0, fifo_wr_data}, 32'hF001);
        tick();
        tick();
        src_req  = 4'b0000;
        src_vld  = 4'b0000;
        src_last = 4'b0000;
        settle();
        chk("t6_busy_end", {31'h0, busy}, 32'h0);
        chk_wr("t6_w0", 16'hF001);
        chk_wr("t6_w1", 16'h5500);
        chk_wr("t6_w2", 16'hF001);
        chk_wr("t6_w3", 16'h5510);
        chk("t6_wq_empty", wq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mix_fifo_wr_arb.md
Name: mix_fifo_wr_arb

Overview:
Round-robin burst arbiter that shares the single write port of one prefetch mix FIFO (e.g. the 16-bit, 1024-deep instance) between N_SRC video stream sources.
- Grants one source at a time for a burst of at most BURST_LEN beats, or fewer if the source ends early with last.
- Optionally prepends a header word carrying the source ID, so the read side can demultiplex.
- Sits between the capture/scaler stream outputs and the FIFO wr_en/wr_data/wr_vld port.

Parameters:
- N_SRC, 4, number of requesters (2..8).
- DATA_W, 16, data width; must equal FIFO write width; must be >= 8.
- BURST_LEN, 64, max data beats per grant (1..256).
- HDR_EN, 1, 1 = insert one header word before each burst's data.
- ID_W, 3, source ID width; must satisfy 2^ID_W >= N_SRC.

Ports:
- clk, in, 1, single clock for the whole block.
- rst, in, 1, synchronous active-high reset.
- src_req, in, N_SRC, source i has a burst pending; level signal.
- src_vld, in, N_SRC, source i beat valid.
- src_data, in, N_SRC*DATA_W, source i data in slice [i*DATA_W +: DATA_W].
- src_last, in, N_SRC, final beat of source i's packet.
- src_rdy, out, N_SRC, beat accepted from source i when src_vld[i] & src_rdy[i].
- fifo_wr_en, out, 1, to FIFO wr_en.
- fifo_wr_data, out, DATA_W, to FIFO wr_data.
- fifo_wr_rdy, in, 1, from FIFO wr_vld; 1 = FIFO accepts a write this cycle.
- grant, out, N_SRC, one-hot current owner; 0 when idle.
- grant_id, out, ID_W, binary index of owner; 0 when idle.
- busy, out, 1, state != IDLE.

Behaviour:
- Handshake: a FIFO write occurs only on a cycle where fifo_wr_en & fifo_wr_rdy. The block never drops or duplicates a word.
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE; grant=0, grant_id=0, busy=0, src_rdy=0, fifo_wr_en=0, fifo_wr_data=0.
  - beat counter=0.
  - RR pointer last=N_SRC-1, so source 0 has top priority after reset.
  - Reset mid-burst aborts the burst immediately. No further FIFO writes occur; the partial burst already in the FIFO stays there.
- State IDLE:
  - If src_req != 0, pick the first set bit scanning from last+1 upward with wrap-around.
  - Register grant/grant_id; set last to the chosen index.
  - Go to HDR if HDR_EN=1, else XFER.
  - Arbitration costs exactly one cycle. No write happens in IDLE.
- State HDR:
  - fifo_wr_en=1; fifo_wr_data = {4'hF, zeros, grant_id}, i.e. bits [DATA_W-1:DATA_W-4]=4'hF, bits [ID_W-1:0]=grant_id, others 0.
  - src_rdy=0.
  - Stay in HDR while fifo_wr_rdy=0, holding data stable. On accept, go to XFER.
- State XFER (g = owner):
  - Combinational forwarding: fifo_wr_en=src_vld[g]; fifo_wr_data=src_data slice g; src_rdy[g]=fifo_wr_rdy; src_rdy of all other sources = 0.
  - Beat counter increments on each accepted beat.
  - Burst ends on the accepted beat where src_last[g]=1 OR counter==BURST_LEN-1. Then counter→0, grant→0, state→IDLE.
  - If BURST_LEN is reached without last, the source keeps its packet. Its remaining beats continue in a later grant, with a new header.
  - src_vld low or fifo_wr_rdy low: stall, no counter change, grant held indefinitely (no timeout).
- src_req dropping during XFER is ignored; only last or BURST_LEN ends a grant.
- Simultaneous requests: the round-robin order guarantees each requesting source a grant within N_SRC bursts.
- Latency:
  - From src_req rising (in IDLE) to the header on fifo_wr_en: 1 cycle.
  - From header accept to first data beat: 0 cycles.
- Minimum cycles per burst: 1 (arb) + HDR_EN + beats.
- Throughput target: continuous source data at fifo_wr_rdy=1 achieves beats/(beats+1+HDR_EN) efficiency.

Test Plan:
- Reset behaviour: assert rst with src_req=4'b1111 -> all outputs 0. After release: grant=4'b0001 one cycle later; header word 16'hF000 written; then source 0 data.
- Single source, 3-beat packet with last, values 0x0011, 0x0022, 0x0033 -> FIFO receives F000, 0011, 0022, 0033. busy falls the cycle after the 0x0033 accept.
- BURST_LEN=4, source 2 streams 10 beats with last on beat 10, others idle -> three bursts: header F002 then 4 + 4 + 2 data beats; exactly one IDLE cycle between bursts.
- All four sources request continuously, 1-beat packets -> grant sequence 0,1,2,3,0,1… and header IDs F000, F001, F002, F003, F000.
- Backpressure: hold fifo_wr_rdy=0 for 5 cycles during HDR and again mid-XFER -> header and data held stable, src_rdy[g]=0, no counter advance; no lost or duplicated words versus the reference model.
- Reset asserted on beat 2 of a 4-beat burst -> next cycle: fifo_wr_en=0, grant=0; after release, arbitration restarts at source 0.
